upsample_unit: RTL and testbench
================================

# upsample_unit

Streaming 2x nearest-neighbour upsampler, the inverse-direction counterpart of the 2x2 max-pool stage. It accepts a raster-order 8-bit pixel stream of an IMG_W x IMG_H map and emits a raster-order (2·IMG_W) x (2·IMG_H) stream. Each input pixel is replicated into a 2x2 output block. One line buffer holds the current input row so that it can be replayed for the odd output row. It sits on the decoder/reconstruction side of the pipeline, with a ready/valid handshake on both ends.

## Interface
- IMG_W, 14, input map width in pixels (output width 2·IMG_W); must be ≥1
- IMG_H, 14, input map height in rows (output height 2·IMG_H); must be ≥1
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  in_data holds a valid input pixel
- in_ready  output  1  block accepts in_data this cycle (combinational from state; forced 0 while rst_n=0)
- in_data  input  8  input pixel, unsigned
- out_ready  input  1  downstream accepts the output beat
- out_valid  output  1  out_data/out_last valid (registered)
- out_data  output  8  output pixel (registered)
- out_last  output  1  marks final beat of an output frame (registered, qualified by out_valid)

## Operation
- Internal state:
  - row_buf[0:IMG_W-1] x 8b
  - col counter 0..IMG_W-1
  - row counter 0..IMG_H-1
  - sub bit (copy index 0/1)
  - FSM {ROW_EVEN, ROW_ODD}
- slot_free = !out_valid || out_ready. The output register may be loaded only when slot_free.
- ROW_EVEN (first output row of each pair):
  - in_ready = slot_free && sub==0.
  - On accept (in_valid && in_ready): out_data<=in_data, row_buf[col]<=in_data, out_valid<=1, sub<=1.
  - sub==1 && slot_free: out_valid<=1, out_data unchanged (second copy), sub<=0, col++.
  - When col==IMG_W-1 completes its second copy: col<=0, go to ROW_ODD.
- ROW_ODD (replay):
  - in_ready=0; in_data is ignored.
  - Each slot_free cycle loads out_data<=row_buf[col], out_valid<=1, and toggles sub. Col increments after sub==1.
  - After col==IMG_W-1 sub==1: col<=0; if row==IMG_H-1 then row<=0, else row++. Return to ROW_EVEN.
- out_last<=1 exactly when loading the ROW_ODD beat with row==IMG_H-1, col==IMG_W-1, sub==1. It is cleared on any other load.
- Idle: when slot_free with nothing to load (ROW_EVEN, sub==0, no accept), out_valid<=0; out_data and out_last hold.
- Output mapping: out pixel (R,C) = in pixel (R>>1, C>>1). There are 4·IMG_W·IMG_H beats per frame.
- Frames run back-to-back with no bubble, and counters wrap automatically. There is no frame start signal; alignment comes from reset only.

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_last=0
  - FSM=ROW_EVEN, col=row=sub=0, row_buf all 0
  - in_ready=0 during reset, 1 in the first cycle after rst_n rises
- Latency: input accepted at edge t appears on out_data/out_valid after edge t, with its second copy one accepted beat later.
- Throughput: with in_valid=1 and out_ready=1, out_valid stays 1 every cycle. in_ready toggles 1,0 during even rows and stays 0 for 2·IMG_W cycles during odd rows.
- Stall: while out_valid=1 && out_ready=0, out_data, out_last, and all state hold, and in_ready=0.
- in_valid may drop at any time. The block waits at the current position and is not required to hold out_valid.
- Reset asserted mid-frame: immediate return to reset values. The next frame begins at input pixel (0,0).

## Test plan
- Full frame, default params, in_data = (r·14+c) mod 256, in_valid=1, out_ready=1. Required:
  - exactly 784 beats, all contiguous
  - beats 0..3 = 0,0,1,1
  - beat 28 = 0
  - beat 783 = 195 with out_last=1
  - out_last=0 on all other beats
- Random out_ready (50%) with a full frame. Required:
  - identical beat sequence
  - out_data and out_last stable on every stalled cycle
  - no input accepted while stalled
- Random in_valid gaps (30% idle) with out_ready=1. Required: identical beat sequence, and out_valid=0 only in cycles following a missed accept.
- Reset pulse after 100 output beats, then a fresh frame. Required:
  - out_valid=0 immediately
  - the next frame's first beats equal in(0,0) twice
  - 784 beats, with out_last on the last beat only
- Two back-to-back frames, ready always high. Required: frame 2 beat 0 follows frame 1's out_last with no idle cycle, and frame 2 is correct.
- IMG_W=1, IMG_H=2, inputs 7, 9. Required: outputs 7,7,7,7,9,9,9,9, with out_last on the 8th beat.

Source files
------------

// File: rtl/upsample_unit.sv
// Streaming 2x nearest-neighbour upsampler.
//
// Takes a raster-order IMG_W x IMG_H stream of 8-bit pixels and produces a
// raster-order (2*IMG_W) x (2*IMG_H) stream. Each input pixel becomes a 2x2
// block of identical output pixels. While an input row is streamed in (even
// output row) it is also written to a line buffer. That buffer is then
// replayed for the odd output row.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input pixel valid
//   in_ready   block accepts in_data this cycle (combinational, 0 in reset)
//   in_data    input pixel
//   out_ready  downstream accepts the output beat
//   out_valid  output beat valid (registered)
//   out_data   output pixel (registered)
//   out_last   last beat of the output frame (registered)
module upsample_unit #(
  parameter int unsigned IMG_W = 14,
  parameter int unsigned IMG_H = 14
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last
);

  localparam int unsigned ColW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RowW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [ColW-1:0] ColMax = ColW'(IMG_W - 1);
  localparam logic [RowW-1:0] RowMax = RowW'(IMG_H - 1);

  typedef enum logic {StRowEven, StRowOdd} state_e;

  state_e          state_q, state_d;
  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  logic            sub_q, sub_d;
  logic            out_valid_q, out_valid_d;
  logic [7:0]      out_data_q, out_data_d;
  logic            out_last_q, out_last_d;
  logic [7:0]      row_buf_q [IMG_W];

  logic slot_free;
  logic accept;
  logic buf_we;
  logic col_last;
  logic row_last;

  always_comb begin
    slot_free = !out_valid_q || out_ready;
    // Only the first copy of an even-row pixel consumes input.
    in_ready  = rst_n && (state_q == StRowEven) && slot_free && !sub_q;
    accept    = in_valid && in_ready;
    col_last  = (col_q == ColMax);
    row_last  = (row_q == RowMax);

    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    sub_d       = sub_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    buf_we      = 1'b0;

    if (slot_free) begin
      unique case (state_q)
        StRowEven: begin
          if (sub_q) begin
            // Second copy: out_data already holds the pixel.
            out_valid_d = 1'b1;
            out_last_d  = 1'b0;
            sub_d       = 1'b0;
            if (col_last) begin
              col_d   = '0;
              state_d = StRowOdd;
            end else begin
              col_d = col_q + 1'b1;
            end
          end else if (accept) begin
            out_data_d  = in_data;
            out_valid_d = 1'b1;
            out_last_d  = 1'b0;
            sub_d       = 1'b1;
            buf_we      = 1'b1;
          end else begin
            // Nothing to send; data and last hold.
            out_valid_d = 1'b0;
          end
        end
        StRowOdd: begin
          out_data_d  = row_buf_q[col_q];
          out_valid_d = 1'b1;
          out_last_d  = sub_q && row_last && col_last;
          sub_d       = !sub_q;
          if (sub_q) begin
            if (col_last) begin
              col_d   = '0;
              row_d   = row_last ? '0 : row_q + 1'b1;
              state_d = StRowEven;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRowEven;
      col_q       <= '0;
      row_q       <= '0;
      sub_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      for (int i = 0; i < int'(IMG_W); i++) begin
        row_buf_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      sub_q       <= sub_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      if (buf_we) begin
        row_buf_q[col_q] <= in_data;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_upsample_unit.sv
// Self-checking bench for upsample_unit: a default 14x14 instance driven
// with random handshakes against a queue-based reference model, plus a 1x2
// instance for the minimal-size case.
module tb_upsample_unit;

  localparam int W = 14;
  localparam int H = 14;
  localparam int FrameBeats = 4 * W * H;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       in_valid, in_ready, out_ready, out_valid, out_last;
  logic [7:0] in_data, out_data;

  logic       s_in_valid, s_in_ready, s_out_ready, s_out_valid, s_out_last;
  logic [7:0] s_in_data, s_out_data;

  always #5 clk = ~clk;

  upsample_unit #(.IMG_W(W), .IMG_H(H)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last)
  );

  upsample_unit #(.IMG_W(1), .IMG_H(2)) u_dut_small (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (s_in_valid),
    .in_ready (s_in_ready),
    .in_data  (s_in_data),
    .out_ready(s_out_ready),
    .out_valid(s_out_valid),
    .out_data (s_out_data),
    .out_last (s_out_last)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_beats;
  int n_idle;

  logic [7:0] pix_q[$];
  logic [7:0] exp_data[$];
  logic       exp_last[$];
  logic [7:0] cap_data[$];
  logic       cap_last[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: output (R,C) = input (R/2, C/2), last on the final beat.
  task automatic add_frame(input bit ramp);
    int base;
    base = pix_q.size();
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        pix_q.push_back(ramp ? 8'((r * W + c) % 256) : 8'($urandom));
      end
    end
    for (int rr = 0; rr < 2 * H; rr++) begin
      for (int cc = 0; cc < 2 * W; cc++) begin
        exp_data.push_back(pix_q[base + (rr / 2) * W + cc / 2]);
        exp_last.push_back((rr == 2 * H - 1) && (cc == 2 * W - 1));
      end
    end
  endtask

  task automatic clear_model();
    pix_q.delete();
    exp_data.delete();
    exp_last.delete();
  endtask

  // Starts and ends one step after a rising edge. stop_after>0 aborts early.
  task automatic run_stream(input int vgap, input int rdy, input int stop_after);
    int cyc, in_idx, target, budget;
    logic prev_stall, prev_ir, prev_iv, prev_last;
    logic [7:0] prev_data, e_data;
    logic e_last;
    cyc = 0;
    in_idx = 0;
    n_beats = 0;
    n_idle = 0;
    prev_stall = 1'b0;
    prev_ir = 1'b0;
    prev_iv = 1'b0;
    prev_last = 1'b0;
    prev_data = '0;
    cap_data.delete();
    cap_last.delete();
    target = (stop_after > 0) ? stop_after : exp_data.size();
    budget = 20 * target + 100;
    while (n_beats < target && cyc < budget) begin
      in_valid  = (in_idx < pix_q.size()) && ($urandom_range(99) >= vgap);
      in_data   = in_valid ? pix_q[in_idx] : 8'($urandom);
      out_ready = ($urandom_range(99) < rdy);
      @(negedge clk);
      if (prev_stall) begin
        check_eq("stall_valid", out_valid, 1);
        check_eq("stall_data", out_data, prev_data);
        check_eq("stall_last", out_last, prev_last);
      end
      if (out_valid && !out_ready) check_eq("stall_in_ready", in_ready, 0);
      if (rdy == 100 && cyc > 0 && !out_valid) begin
        n_idle++;
        check_eq("bubble_cause", prev_ir && !prev_iv, 1);
      end
      if (out_valid && out_ready) begin
        if (exp_data.size() == 0) begin
          check_eq("extra_beat", 1, 0);
        end else begin
          e_data = exp_data.pop_front();
          e_last = exp_last.pop_front();
          check_eq($sformatf("data[%0d]", n_beats), out_data, e_data);
          check_eq($sformatf("last[%0d]", n_beats), out_last, e_last);
        end
        cap_data.push_back(out_data);
        cap_last.push_back(out_last);
        n_beats++;
      end
      if (in_valid && in_ready) in_idx++;
      prev_stall = out_valid && !out_ready;
      prev_ir = in_ready;
      prev_iv = in_valid;
      prev_data = out_data;
      prev_last = out_last;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (n_beats < target) check_eq("timeout_beats", n_beats, target);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic run_small();
    int idx, cyc, beats;
    idx = 0;
    cyc = 0;
    beats = 0;
    while (beats < 8 && cyc < 60) begin
      s_in_valid  = (idx < 2);
      s_in_data   = (idx == 0) ? 8'd7 : 8'd9;
      s_out_ready = 1'b1;
      @(negedge clk);
      if (s_out_valid) begin
        check_eq($sformatf("small_data[%0d]", beats), s_out_data, (beats < 4) ? 7 : 9);
        check_eq($sformatf("small_last[%0d]", beats), s_out_last, beats == 7);
        beats++;
      end
      if (s_in_valid && s_in_ready) idx++;
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq("small_beats", beats, 8);
    s_in_valid = 1'b0;
  endtask

  initial begin
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    s_in_valid = 1'b0;
    s_in_data = '0;
    s_out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_last", out_last, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Minimal 1x2 map
    run_small();

    // Full ramp frame, no back-pressure
    clear_model();
    add_frame(1'b1);
    run_stream(0, 100, 0);
    check_eq("t1_beats", n_beats, FrameBeats);
    check_eq("t1_idle", n_idle, 0);
    if (cap_data.size() == FrameBeats) begin
      check_eq("t1_b0", cap_data[0], 0);
      check_eq("t1_b1", cap_data[1], 0);
      check_eq("t1_b2", cap_data[2], 1);
      check_eq("t1_b3", cap_data[3], 1);
      check_eq("t1_b28", cap_data[28], 0);
      check_eq("t1_b783", cap_data[783], 195);
      check_eq("t1_last783", cap_last[783], 1);
    end

    // Random back-pressure
    clear_model();
    add_frame(1'b1);
    run_stream(0, 50, 0);
    check_eq("t2_beats", n_beats, FrameBeats);

    // Random input gaps
    clear_model();
    add_frame(1'b1);
    run_stream(30, 100, 0);
    check_eq("t3_beats", n_beats, FrameBeats);

    // Reset mid-frame after 100 beats
    clear_model();
    add_frame(1'b0);
    run_stream(0, 100, 100);
    rst_n = 1'b0;
    #1;
    check_eq("t4_rst_valid", out_valid, 0);
    check_eq("t4_rst_in_ready", in_ready, 0);
    check_eq("t4_rst_last", out_last, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_model();
    add_frame(1'b0);
    run_stream(10, 70, 0);
    check_eq("t4_beats", n_beats, FrameBeats);
    if (cap_data.size() >= 2) begin
      check_eq("t4_first0", cap_data[0], pix_q[0]);
      check_eq("t4_first1", cap_data[1], pix_q[0]);
    end

    // Two frames back-to-back
    clear_model();
    add_frame(1'b0);
    add_frame(1'b0);
    run_stream(0, 100, 0);
    check_eq("t5_beats", n_beats, 2 * FrameBeats);
    check_eq("t5_idle", n_idle, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
